apb_wait_slave: RTL and testbench
=================================

APB_WAIT_SLAVE -- requirements
Module: apb_wait_slave

Interface
REQ-001 Parameter ADD_WIDTH, default 8: APB word-address width (paddr).
REQ-002 Parameter WIDTH, default 32: data width of pwdata and prdata.
REQ-003 Parameter MEM_DEPTH, default 64: number of implemented words, at addresses 0..MEM_DEPTH-1; MEM_DEPTH SHALL be <= 2**ADD_WIDTH.
REQ-004 Parameter WAIT_CYCLES, default 2, range 0..15: wait states inserted in every access phase.
REQ-005 pclk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-006 preset  input  1  synchronous, active-high reset, sampled on the rising edge of pclk.
REQ-007 psel  input  1  slave select from the APB requester.
REQ-008 penable  input  1  access-phase strobe.
REQ-009 pwrite  input  1  1 = write, 0 = read.
REQ-010 paddr  input  ADD_WIDTH  word address.
REQ-011 pwdata  input  WIDTH  write data.
REQ-012 prdata  output  WIDTH  read data, registered.
REQ-013 pready  output  1  transfer completion, registered.
REQ-014 pslverr  output  1  transfer error, registered; valid only while pready=1.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and ACCESS.
REQ-016 In IDLE, when psel=1 and penable=0 (setup cycle), the block SHALL capture paddr, pwrite and pwdata.
REQ-017 On a setup cycle with WAIT_CYCLES>0, the next state SHALL be WAIT and the wait counter SHALL load WAIT_CYCLES.
REQ-018 On a setup cycle with WAIT_CYCLES=0, the next state SHALL be ACCESS.
REQ-019 In WAIT with psel=1: if counter=1, next state SHALL be ACCESS; otherwise the counter SHALL decrement.
REQ-020 In WAIT, psel=0 SHALL abort to IDLE with no memory write and no pready pulse.
REQ-021 In ACCESS, pready SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-022 Latency: pready SHALL rise exactly WAIT_CYCLES+1 cycles after the setup cycle, giving a transfer length of WAIT_CYCLES+2 cycles.
REQ-023 pready SHALL be 0 in IDLE and WAIT.
REQ-024 A captured address >= MEM_DEPTH SHALL set pslverr=1 during ACCESS, suppress the write, and drive prdata=0.
REQ-025 For an in-range read, prdata SHALL hold mem[captured addr] during the ACCESS cycle and be 0 in every other cycle.
REQ-026 For an in-range write, mem[captured addr] SHALL take the captured pwdata at the edge that ends ACCESS, only if psel=1 and penable=1 in that cycle.
REQ-027 If psel=0 in the ACCESS cycle, the write SHALL be dropped; pready SHALL still pulse and the FSM SHALL still return to IDLE.
REQ-028 In IDLE, psel=1 with penable=1 (no setup phase) SHALL be ignored: the state stays IDLE and pready stays 0.
REQ-029 Back-to-back transfers: a setup cycle in the cycle immediately after ACCESS SHALL be accepted with the same latency.
REQ-030 Read-after-write to the same address SHALL return the newly written data.
REQ-031 Changes on paddr, pwrite or pwdata after the setup cycle SHALL have no effect on the transfer in progress.

Reset
REQ-032 While preset=1, the FSM SHALL go to IDLE, the wait counter SHALL clear, and prdata=0, pready=0, pslverr=0.
REQ-033 While preset=1, all MEM_DEPTH words SHALL clear to 0.
REQ-034 Reset asserted during WAIT or ACCESS SHALL abandon the transfer with no write and no pready pulse, and outputs SHALL be zero on the next edge.

Verification
REQ-035 Write then read, default parameters: write addr 0x05 data 0xDEADBEEF, then read 0x05 -> pready high in cycle 3 after each setup cycle, pslverr=0, prdata=0xDEADBEEF.
REQ-036 Out-of-range access, MEM_DEPTH=64: write 0x50 data 0x12345678, then read 0x50 -> pslverr=1 with pready on both transfers, prdata=0; a subsequent read of every word 0..63 returns 0.
REQ-037 Abort: setup a write to 0x0A, then drop psel in the first WAIT cycle -> no pready pulse, FSM returns to IDLE, later read of 0x0A = 0.
REQ-038 Zero wait, WAIT_CYCLES=0: back-to-back writes to 0x01 then 0x02, followed by reads -> pready in the cycle after each setup cycle, data matches.
REQ-039 Reset mid-transfer: assert preset in the second WAIT cycle of a write to 0x03 -> pready, pslverr and prdata are 0 on the next edge; read of 0x03 after reset = 0.
REQ-040 Illegal start: psel=1 and penable=1 held from IDLE for 3 cycles -> pready stays 0 and memory is unchanged.

Source files
------------

// File: rtl/apb_wait_slave.sv
// APB slave with a word-addressed register memory and a fixed number of wait states.
// Every access phase is stretched by WAIT_CYCLES cycles before pready is pulsed once.
module apb_wait_slave #(
  parameter int ADD_WIDTH   = 8,
  parameter int WIDTH       = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADD_WIDTH-1:0] paddr,
  input  logic [WIDTH-1:0]     pwdata,
  output logic [WIDTH-1:0]     prdata,
  output logic                 pready,
  output logic                 pslverr
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADD_WIDTH:0] DEPTH_L = (ADD_WIDTH+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADD_WIDTH-1:0]   addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic [WIDTH-1:0]       wdata_q, wdata_d;
  logic [WIDTH-1:0]       prdata_q, prdata_d;
  logic                   pready_q, pready_d;
  logic                   pslverr_q, pslverr_d;
  logic [WIDTH-1:0]       mem_q [MEM_DEPTH];

  logic                   in_rng_d, in_rng_q, mem_we;
  logic [IDX_W-1:0]       idx_d, idx_q;

  // Request is latched only on a proper setup cycle; later bus changes are ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          wr_d    = pwrite;
          wdata_d = pwdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are computed from the state being entered.
  always_comb begin
    in_rng_d  = ({1'b0, addr_d} < DEPTH_L);
    in_rng_q  = ({1'b0, addr_q} < DEPTH_L);
    idx_d     = addr_d[IDX_W-1:0];
    idx_q     = addr_q[IDX_W-1:0];
    mem_we    = (state_q == ACCESS) && wr_q && psel && penable && in_rng_q;
    pready_d  = (state_d == ACCESS);
    pslverr_d = (state_d == ACCESS) && !in_rng_d;
    prdata_d  = '0;
    if ((state_d == ACCESS) && !wr_d && in_rng_d) begin
      prdata_d = mem_q[idx_d];
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      if (mem_we) begin
        mem_q[idx_q] <= wdata_q;
      end
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed bench for apb_wait_slave: instance 0 uses two wait states, instance 1 uses none.
module tb_apb_wait_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        preset;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [7:0]  paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  apb_wait_slave #(.ADD_WIDTH(8), .WIDTH(32), .MEM_DEPTH(64), .WAIT_CYCLES(2)) dut0 (
    .pclk(clk), .preset(preset), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0])
  );

  apb_wait_slave #(.ADD_WIDTH(8), .WIDTH(32), .MEM_DEPTH(64), .WAIT_CYCLES(0)) dut1 (
    .pclk(clk), .preset(preset), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1])
  );

  typedef struct {
    int          d;
    bit          wr;
    logic [7:0]  a;
    logic [31:0] wd;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  int ntot  = 0;
  int npass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // One complete transfer; returns at the negedge of the ACCESS cycle with psel/penable still high.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      input bit err, input logic [31:0] rd, input string nm);
    int lat;
    bit got;
    int w;
    w = (d == 0) ? 2 : 0;
    @(negedge clk);
    chk({nm, ".idle_rdy"}, 32'(pready[d]), 32'h0);
    chk({nm, ".idle_rdata"}, prdata[d], 32'h0);
    psel[1-d] = 1'b0; penable[1-d] = 1'b0;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        penable[d] = 1'b1;
        paddr[d]   = ~a;
        pwdata[d]  = ~wd;
        pwrite[d]  = ~wr;
      end
      if (pready[d]) begin
        got = 1'b1;
        lat = k;
        chk({nm, ".pslverr"}, 32'(pslverr[d]), 32'(err));
        chk({nm, ".prdata"}, prdata[d], rd);
      end
    end
    chk({nm, ".latency"}, 32'(lat), 32'(w + 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      psel[0] = 1'b0; penable[0] = 1'b0;
      psel[1] = 1'b0; penable[1] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    preset = 1'b1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (2) @(negedge clk);
    preset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];

    preset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d.pready", d), 32'(pready[d]), 32'h0);
      chk($sformatf("rst%0d.pslverr", d), 32'(pslverr[d]), 32'h0);
      chk($sformatf("rst%0d.prdata", d), prdata[d], 32'h0);
    end
    preset = 1'b0;

    tbl[0]  = '{0, 1'b1, 8'h05, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{0, 1'b0, 8'h05, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{0, 1'b1, 8'h3F, 32'hA5A50001, 1'b0, 32'h0};
    tbl[3]  = '{0, 1'b0, 8'h3F, 32'h0,        1'b0, 32'hA5A50001};
    tbl[4]  = '{0, 1'b1, 8'h40, 32'h12121212, 1'b1, 32'h0};
    tbl[5]  = '{0, 1'b0, 8'h40, 32'h0,        1'b1, 32'h0};
    tbl[6]  = '{1, 1'b1, 8'h01, 32'h11111111, 1'b0, 32'h0};
    tbl[7]  = '{1, 1'b1, 8'h02, 32'h22222222, 1'b0, 32'h0};
    tbl[8]  = '{1, 1'b0, 8'h01, 32'h0,        1'b0, 32'h11111111};
    tbl[9]  = '{1, 1'b0, 8'h02, 32'h0,        1'b0, 32'h22222222};
    tbl[10] = '{1, 1'b1, 8'h03, 32'h33333333, 1'b0, 32'h0};
    tbl[11] = '{1, 1'b0, 8'h03, 32'h0,        1'b0, 32'h33333333};

    for (int i = 0; i < 12; i++) begin
      xfer(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].err, tbl[i].rd, $sformatf("v%0d", i));
    end
    idle(2);

    // Out-of-range write must not alias into any implemented word.
    do_reset();
    xfer(0, 1'b1, 8'h50, 32'h12345678, 1'b1, 32'h0, "oor_wr");
    xfer(0, 1'b0, 8'h50, 32'h0, 1'b1, 32'h0, "oor_rd");
    for (int i = 0; i < 64; i++) begin
      xfer(0, 1'b0, 8'(i), 32'h0, 1'b0, 32'h0, $sformatf("scan%0d", i));
    end
    idle(1);

    // Abort: psel dropped in the first WAIT cycle.
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h0A; pwdata[0] = 32'hCAFEF00D;
    @(negedge clk);
    psel[0] = 1'b0; penable[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("abort.rdy%0d", k), 32'(pready[0]), 32'h0);
    end
    xfer(0, 1'b0, 8'h0A, 32'h0, 1'b0, 32'h0, "abort_rd");
    idle(1);

    // Illegal start: psel and penable together from IDLE.
    xfer(0, 1'b1, 8'h07, 32'h77777777, 1'b0, 32'h0, "ill_wr");
    idle(1);
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'h07; pwdata[0] = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ill.rdy%0d", k), 32'(pready[0]), 32'h0);
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    xfer(0, 1'b0, 8'h07, 32'h0, 1'b0, 32'h77777777, "ill_rd");
    idle(1);

    // Reset in the second WAIT cycle of a write.
    @(negedge clk);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h03; pwdata[0] = 32'h0BADF00D;
    @(negedge clk);
    penable[0] = 1'b1;
    @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    chk("midrst.pready", 32'(pready[0]), 32'h0);
    chk("midrst.pslverr", 32'(pslverr[0]), 32'h0);
    chk("midrst.prdata", prdata[0], 32'h0);
    preset = 1'b0;
    psel[0] = 1'b0; penable[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("midrst.rdy%0d", k), 32'(pready[0]), 32'h0);
    end
    xfer(0, 1'b0, 8'h03, 32'h0, 1'b0, 32'h0, "midrst_rd");
    idle(2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
